pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
Central stall/bubble/halt controller for the five-stage pipeline (fetch, decode, execute, memory, writeback).
- Collects stall requests from decode (hazard), execute (multi-cycle ALU) and memory (data-memory wait).
- Produces per-stage enables and bubble-insert strobes, plus the `stallCount` consumed by the hazard units.
- Sequences orderly halt (drain) and deadlock detection.
- Replaces the ad-hoc stall chaining currently wired between stage modules.

Parameters:
- STALL_COUNT_WIDTH, 4, width of `stallCount` (must equal the shared `stall_count_t` width)
- DEADLOCK_LIMIT, 64, consecutive stalled cycles before declaring deadlock (must be ≥ 2)
- DRAIN_CYCLES, 4, cycles fetch stays closed after a halt request before entering HALTED

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on rising clock)
- stallReqDecode  in  1  decode hazard unresolved this cycle
- stallReqExecute  in  1  execute stage busy (multi-cycle op)
- stallReqMemory  in  1  data memory not ready
- haltRequest  in  1  halt-class instruction retired from decode (pulse)
- fetchEnable  out  1  fetch may advance PC / latch instruction
- decodeEnable  out  1  decode pipeline register may load
- executeEnable  out  1  execute pipeline register may load
- memoryEnable  out  1  memory pipeline register may load
- executeBubble  out  1  load NOP into decode→execute register
- memoryBubble  out  1  load NOP into execute→memory register
- writebackBubble  out  1  load NOP into memory→writeback register
- stallCount  out  STALL_COUNT_WIDTH  consecutive decode-stall cycles
- halted  out  1  pipeline drained and stopped (sticky)
- deadlock  out  1  stall limit exceeded (sticky)

Behaviour:

Reset (reset==0):
- State = RUN; all counters 0.
- `halted`=0, `deadlock`=0, `stallCount`=0.
- All enables 1, all bubbles 0.

FSM states: RUN, STALL, DRAIN, HALTED.
- RUN→STALL: any stallReq* = 1.
- STALL→RUN: no stallReq* asserted.
- RUN/STALL→DRAIN: `haltRequest` sampled at 1.
- DRAIN→HALTED: drain counter reaches DRAIN_CYCLES−1 with no stall asserted.
- any→HALTED: deadlock.
- HALTED exits only via reset.

Stall resolution (combinational, same cycle as the requests). Priority memory > execute > decode; only the highest active source applies.
- Memory: fetch/decode/execute/memory enables = 0; `writebackBubble` = 1.
- Execute: fetch/decode/execute enables = 0; `memoryBubble` = 1; memory enable = 1.
- Decode: fetch/decode enables = 0; `executeBubble` = 1; execute/memory enables = 1.
- Bubbles are never asserted while the corresponding downstream register is itself frozen.

DRAIN:
- `fetchEnable` = 0 and `executeBubble` = 1 every cycle. Decode's in-flight instruction is not re-issued; downstream stages advance normally.
- The drain counter does not advance in cycles where any stall is active.
- `haltRequest` while in DRAIN or HALTED is ignored.

HALTED:
- All enables 0, all bubbles 0, `halted` = 1.

stallCount (registered):
- Next value = `stallCount`+1 if `stallReqDecode` is the resolved stall source this cycle, else 0.
- Saturates at 2^W−1 (no wrap).

Deadlock counter (registered):
- Counts consecutive cycles with any stall.
- Clears on the first stall-free cycle.
- Reaching DEADLOCK_LIMIT sets `deadlock` = 1 and forces HALTED on the next edge.
- `halted` and `deadlock` are both 1 in that case.

Simultaneous events:
- `haltRequest` together with a stall: stall resolution applies this cycle, state moves to DRAIN.
- Reset asserted mid-DRAIN or mid-STALL: returns to RUN next edge with all counters cleared.

Optional Feature:
Macro `PIPELINE_PERF_COUNTERS_EN`.
- Defined: adds three 32-bit outputs `perfDecodeStalls`, `perfExecuteStalls`, `perfMemoryStalls`.
  - Each increments once per cycle in which that source is the resolved stall.
  - Each wraps modulo 2^32 and clears on reset.
  - Each is frozen in HALTED.
  - A `$display` line is emitted per stalled cycle naming the source.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared definitions package gets:
  - `sequencer_state_t` enum {RUN, STALL, DRAIN, HALTED}
  - `stall_source_t` enum {NONE, DECODE, EXECUTE, MEMORY}
  - `stage_enables_t` packed struct (four enables + three bubbles)
  - `stall_count_t`, reused as-is
- One natural sub-module: `stall_priority_resolver`, a combinational mapping of the three requests to `stall_source_t` plus `stage_enables_t`.
- The FSM and counters stay in `pipeline_sequencer`.

Test Plan:
- Reset release, no requests for 10 cycles → all enables 1, bubbles 0, `stallCount`=0, `halted`=0.
- `stallReqDecode` high 3 cycles → fetch/decode enables 0 and `executeBubble`=1 those cycles; `stallCount` reads 1,2,3, then 0 after release.
- `stallReqDecode`+`stallReqMemory` together 2 cycles → memory priority: `writebackBubble`=1, `executeBubble`=0, `stallCount` stays 0.
- `stallReqDecode` held 20 cycles with width 4 → `stallCount` saturates at 15.
- `haltRequest` pulse, no stalls → `fetchEnable`=0 for 4 cycles, then `halted`=1, all enables 0.
  - Repeat with `stallReqMemory` for 2 cycles mid-drain → `halted` asserts 2 cycles later.
- `stallReqExecute` held 64 cycles → `deadlock`=1 and `halted`=1 on cycle 65.
  - Then reset low 1 cycle → both clear, enables 1.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline stall/bubble/halt sequencer.
//   sequencer_state_t : FSM encoding (RUN, STALL, DRAIN, HALTED)
//   stall_source_t    : resolved stall source (NONE, DECODE, EXECUTE, MEMORY)
//   stage_enables_t   : four stage enables plus three bubble strobes
//   stall_count_t     : width shared with the hazard units' stall counters
package pipeline_sequencer_pkg;

  localparam int STALL_COUNT_W = 4;

  typedef logic [STALL_COUNT_W-1:0] stall_count_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    DRAIN,
    HALTED
  } sequencer_state_t;

  typedef enum logic [1:0] {
    NONE,
    DECODE,
    EXECUTE,
    MEMORY
  } stall_source_t;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic execute_en;
    logic memory_en;
    logic execute_bubble;
    logic memory_bubble;
    logic writeback_bubble;
  } stage_enables_t;

  // Free-running pipeline: every register loads, no NOPs injected.
  localparam stage_enables_t ENABLES_RUN = '{
    fetch_en: 1'b1, decode_en: 1'b1, execute_en: 1'b1, memory_en: 1'b1,
    execute_bubble: 1'b0, memory_bubble: 1'b0, writeback_bubble: 1'b0
  };

endpackage

// File: rtl/pipeline_sequencer_stall_priority_resolver.sv
// Combinational stall priority resolver.
// Maps the three stall requests to the single winning source and the
// matching stage enables / bubble strobes. Priority: memory > execute > decode.
// Ports:
//   stall_decode, stall_execute, stall_memory : raw stall requests
//   source                                   : winning stall source (NONE if idle)
//   enables                                  : stage enables + bubble strobes
module stall_priority_resolver
  import pipeline_sequencer_pkg::*;
(
  input  logic           stall_decode,
  input  logic           stall_execute,
  input  logic           stall_memory,
  output stall_source_t  source,
  output stage_enables_t enables
);

  // Each stage upstream of the stalling one freezes; the register directly
  // downstream of the stalling stage gets a NOP so younger work is not
  // duplicated. A bubble only targets a register that is still loading.
  always_comb begin
    source  = NONE;
    enables = ENABLES_RUN;
    if (stall_memory) begin
      source                   = MEMORY;
      enables.fetch_en         = 1'b0;
      enables.decode_en        = 1'b0;
      enables.execute_en       = 1'b0;
      enables.memory_en        = 1'b0;
      enables.writeback_bubble = 1'b1;
    end else if (stall_execute) begin
      source                = EXECUTE;
      enables.fetch_en      = 1'b0;
      enables.decode_en     = 1'b0;
      enables.execute_en    = 1'b0;
      enables.memory_bubble = 1'b1;
    end else if (stall_decode) begin
      source                 = DECODE;
      enables.fetch_en       = 1'b0;
      enables.decode_en      = 1'b0;
      enables.execute_bubble = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/bubble/halt controller for the five-stage pipeline.
// Optional feature macro: PIPELINE_PERF_COUNTERS_EN (per-source stall counters).
// Ports:
//   clock, reset (synchronous, active-low)
//   stallReqDecode/Execute/Memory : level stall requests, honoured the same cycle
//   haltRequest                   : pulse, starts an orderly drain
//   fetch/decode/execute/memoryEnable : pipeline register load enables
//   execute/memory/writebackBubble    : load NOP into the named register
//   stallCount : consecutive decode-stall cycles (saturating)
//   halted, deadlock : sticky status flags, cleared only by reset
//   state      : current FSM state (debug visibility)
//   perfDecodeStalls/ExecuteStalls/MemoryStalls : only with the macro defined
// Request semantics: a stage holds its stallReq high for as long as it needs
// the pipeline frozen; the enables returned in that same cycle are final.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int STALL_COUNT_WIDTH = STALL_COUNT_W,  // keep equal to stall_count_t width
  parameter int DEADLOCK_LIMIT    = 64,             // must be >= 2
  parameter int DRAIN_CYCLES      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stallReqDecode,
  input  logic                         stallReqExecute,
  input  logic                         stallReqMemory,
  input  logic                         haltRequest,
  output logic                         fetchEnable,
  output logic                         decodeEnable,
  output logic                         executeEnable,
  output logic                         memoryEnable,
  output logic                         executeBubble,
  output logic                         memoryBubble,
  output logic                         writebackBubble,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount,
  output logic                         halted,
  output logic                         deadlock,
  output sequencer_state_t             state
`ifdef PIPELINE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                  perfDecodeStalls,
  output logic [31:0]                  perfExecuteStalls,
  output logic [31:0]                  perfMemoryStalls
`endif
);

  localparam int DL_W = $clog2(DEADLOCK_LIMIT + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  stall_source_t  src_raw;
  stall_source_t  src;
  stage_enables_t en_raw;
  stage_enables_t en;
  logic           any_stall;
  logic           dl_hit;
  logic [DL_W-1:0] dl_cnt;
  logic [DR_W-1:0] drain_cnt;

  stall_priority_resolver u_resolver (
    .stall_decode  (stallReqDecode),
    .stall_execute (stallReqExecute),
    .stall_memory  (stallReqMemory),
    .source        (src_raw),
    .enables       (en_raw)
  );

  // Once halted the pipeline is frozen: requests no longer resolve to a source,
  // so every counter stops.
  assign src       = (state == HALTED) ? NONE : src_raw;
  assign any_stall = (src != NONE);
  assign dl_hit    = any_stall && (dl_cnt == DL_W'(DEADLOCK_LIMIT - 1));

  always_comb begin
    en = en_raw;
    case (state)
      DRAIN: begin
        // Fetch stays closed; the decode->execute register takes NOPs whenever
        // it is loading so the instruction held in decode is never re-issued.
        en.fetch_en       = 1'b0;
        en.execute_bubble = en_raw.execute_en;
      end
      HALTED:  en = '0;
      default: ;
    endcase
  end

  assign fetchEnable     = en.fetch_en;
  assign decodeEnable    = en.decode_en;
  assign executeEnable   = en.execute_en;
  assign memoryEnable    = en.memory_en;
  assign executeBubble   = en.execute_bubble;
  assign memoryBubble    = en.memory_bubble;
  assign writebackBubble = en.writeback_bubble;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      dl_cnt     <= '0;
      drain_cnt  <= '0;
      stallCount <= '0;
      halted     <= 1'b0;
      deadlock   <= 1'b0;
    end else begin
      if (src == DECODE) begin
        if (stallCount != {STALL_COUNT_WIDTH{1'b1}})
          stallCount <= stallCount + STALL_COUNT_WIDTH'(1);
      end else begin
        stallCount <= '0;
      end

      if (state != HALTED)
        dl_cnt <= any_stall ? dl_cnt + DL_W'(1) : '0;

      if (dl_hit) begin
        state    <= HALTED;
        halted   <= 1'b1;
        deadlock <= 1'b1;
      end else begin
        case (state)
          RUN, STALL: begin
            if (haltRequest) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= any_stall ? STALL : RUN;
            end
          end
          DRAIN: begin
            // Stalled cycles do not count toward the drain.
            if (!any_stall) begin
              if (drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                drain_cnt <= drain_cnt + DR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PIPELINE_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perfDecodeStalls  <= '0;
      perfExecuteStalls <= '0;
      perfMemoryStalls  <= '0;
    end else begin
      if (src == DECODE)  perfDecodeStalls  <= perfDecodeStalls + 32'd1;
      if (src == EXECUTE) perfExecuteStalls <= perfExecuteStalls + 32'd1;
      if (src == MEMORY)  perfMemoryStalls  <= perfMemoryStalls + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && any_stall)
      $display("[pipeline_sequencer] stall source %s", src.name());
  end
`endif
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: inputs change 1 time unit after the
// rising edge, combinational outputs are checked 1 unit later, and registered
// outputs are checked 1 unit after the following edge.
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  logic clock;
  logic reset;
  logic stallReqDecode, stallReqExecute, stallReqMemory, haltRequest;
  logic fetchEnable, decodeEnable, executeEnable, memoryEnable;
  logic executeBubble, memoryBubble, writebackBubble;
  logic [3:0] stallCount;
  logic halted, deadlock;
  sequencer_state_t state;

  int tests = 0;
  int failed = 0;

  // {fetch, decode, execute, memory, exeBubble, memBubble, wbBubble}
  localparam logic [31:0] EN_RUN   = 32'b111_1000;
  localparam logic [31:0] EN_DEC   = 32'b001_1100;
  localparam logic [31:0] EN_EXE   = 32'b000_1010;
  localparam logic [31:0] EN_MEM   = 32'b000_0001;
  localparam logic [31:0] EN_DRAIN = 32'b011_1100;
  localparam logic [31:0] EN_OFF   = 32'b000_0000;

  pipeline_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .stallReqDecode  (stallReqDecode),
    .stallReqExecute (stallReqExecute),
    .stallReqMemory  (stallReqMemory),
    .haltRequest     (haltRequest),
    .fetchEnable     (fetchEnable),
    .decodeEnable    (decodeEnable),
    .executeEnable   (executeEnable),
    .memoryEnable    (memoryEnable),
    .executeBubble   (executeBubble),
    .memoryBubble    (memoryBubble),
    .writebackBubble (writebackBubble),
    .stallCount      (stallCount),
    .halted          (halted),
    .deadlock        (deadlock),
    .state           (state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] en_obs();
    return {25'd0, fetchEnable, decodeEnable, executeEnable, memoryEnable,
            executeBubble, memoryBubble, writebackBubble};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dec, input logic exe, input logic mem, input logic hlt);
    stallReqDecode  = dec;
    stallReqExecute = exe;
    stallReqMemory  = mem;
    haltRequest     = hlt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("reset_en", en_obs(), EN_RUN);
    check("reset_cnt", 32'(stallCount), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_deadlock", 32'(deadlock), 32'd0);
    check("reset_state", 32'(state), 32'(RUN));
    reset = 1'b1;

    // Idle run
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_en", en_obs(), EN_RUN);
      check("idle_cnt", 32'(stallCount), 32'd0);
      check("idle_halted", 32'(halted), 32'd0);
    end

    // Decode stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      #1 check("dec_en", en_obs(), EN_DEC);
      tick();
      check("dec_cnt", 32'(stallCount), 32'(i + 1));
      check("dec_state", 32'(state), 32'(STALL));
    end
    drive(0, 0, 0, 0);
    #1 check("dec_release_en", en_obs(), EN_RUN);
    tick();
    check("dec_release_cnt", 32'(stallCount), 32'd0);
    check("dec_release_state", 32'(state), 32'(RUN));

    // Decode + memory: memory wins
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0);
      #1 check("prio_mem_en", en_obs(), EN_MEM);
      tick();
      check("prio_mem_cnt", 32'(stallCount), 32'd0);
    end
    // Decode + execute: execute wins
    drive(1, 1, 0, 0);
    #1 check("prio_exe_en", en_obs(), EN_EXE);
    tick();
    check("prio_exe_cnt", 32'(stallCount), 32'd0);
    drive(0, 0, 0, 0);
    tick();

    // Decode held 20 cycles: saturate at 15
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0);
      tick();
      check("sat_cnt", 32'(stallCount), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    drive(0, 0, 0, 0);
    tick();
    check("sat_release_cnt", 32'(stallCount), 32'd0);

    // Halt with no stalls: 4 drain cycles, then halted
    drive(0, 0, 0, 1);
    #1 check("halt_req_en", en_obs(), EN_RUN);
    tick();
    drive(0, 0, 0, 0);
    check("drain_state", 32'(state), 32'(DRAIN));
    for (int i = 0; i < 4; i++) begin
      #1 check("drain_en", en_obs(), EN_DRAIN);
      check("drain_halted", 32'(halted), 32'd0);
      tick();
    end
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_en", en_obs(), EN_OFF);
    check("halt_state", 32'(state), 32'(HALTED));
    check("halt_deadlock", 32'(deadlock), 32'd0);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    check("halt_sticky", 32'(halted), 32'd1);
    do_reset();
    check("post_halt_reset_en", en_obs(), EN_RUN);

    // Halt with 2 memory-stall cycles mid-drain: drain stretches by 2
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1 check("drain2_en", en_obs(), EN_DRAIN);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0);
      #1 check("drain2_mem_en", en_obs(), EN_MEM);
      tick();
      check("drain2_mem_halted", 32'(halted), 32'd0);
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1 check("drain2_tail_halted", 32'(halted), 32'd0);
      check("drain2_tail_en", en_obs(), EN_DRAIN);
      tick();
    end
    check("drain2_halted", 32'(halted), 32'd1);
    check("drain2_en_off", en_obs(), EN_OFF);
    do_reset();

    // Halt together with a decode stall, then reset mid-drain
    drive(1, 0, 0, 1);
    #1 check("halt_stall_en", en_obs(), EN_DEC);
    tick();
    drive(0, 0, 0, 0);
    check("halt_stall_state", 32'(state), 32'(DRAIN));
    check("halt_stall_cnt", 32'(stallCount), 32'd1);
    tick();
    do_reset();
    check("mid_drain_reset_state", 32'(state), 32'(RUN));
    check("mid_drain_reset_en", en_obs(), EN_RUN);

    // Execute held 64 cycles: deadlock on cycle 65
    drive(0, 1, 0, 0);
    for (int i = 0; i < 64; i++) begin
      #1 check("dl_pending", 32'({deadlock, halted}), 32'd0);
      tick();
    end
    check("dl_deadlock", 32'(deadlock), 32'd1);
    check("dl_halted", 32'(halted), 32'd1);
    check("dl_en", en_obs(), EN_OFF);
    check("dl_state", 32'(state), 32'(HALTED));
    drive(0, 0, 0, 0);
    do_reset();
    check("dl_reset_deadlock", 32'(deadlock), 32'd0);
    check("dl_reset_halted", 32'(halted), 32'd0);
    check("dl_reset_en", en_obs(), EN_RUN);
    check("dl_reset_state", 32'(state), 32'(RUN));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
